// File: rtl/alu_pkg.sv
// alu_pkg: shared word width, types and opcode constants for the ALU.
package alu_pkg;
    localparam int WORD_W = 16;
    typedef logic [WORD_W-1:0] word_t;
    typedef logic [4:0] alu_op_t;
    localparam alu_op_t OP_ADD   = 5'b00000;
    localparam alu_op_t OP_SUB   = 5'b00001;
    localparam alu_op_t OP_AND   = 5'b00010;
    localparam alu_op_t OP_OR    = 5'b00011;
    localparam alu_op_t OP_XOR   = 5'b00100;
    localparam alu_op_t OP_NOT   = 5'b00101;
    localparam alu_op_t OP_NEG   = 5'b00110;
    localparam alu_op_t OP_SHL   = 5'b00111;
    localparam alu_op_t OP_SHR   = 5'b01000;
    localparam alu_op_t OP_SRA   = 5'b01001;
    localparam alu_op_t OP_ROL   = 5'b01010;
    localparam alu_op_t OP_SLT   = 5'b01011;
    localparam alu_op_t OP_SLTU  = 5'b01100;
    localparam alu_op_t OP_MUL   = 5'b01101;
    localparam alu_op_t OP_PASSX = 5'b01110;
    localparam alu_op_t OP_PASSY = 5'b01111;
    localparam alu_op_t OP_ANY   = 5'b10000;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ALU datapath; one shared adder and one shared barrel shifter.
module alu_core #(
    parameter int WORD_W = alu_pkg::WORD_W
) (
    input  logic [4:0]        alu_op,
    input  logic [WORD_W-1:0] x,
    input  logic [WORD_W-1:0] y,
    output logic [WORD_W-1:0] result
);
    import alu_pkg::*;
    localparam int SH_W = $clog2(WORD_W);
    logic              w_sub;
    logic [WORD_W-1:0] w_a;
    logic [WORD_W-1:0] w_b;
    logic [WORD_W-1:0] w_sum;
    logic [WORD_W-1:0] w_mul;
    logic              w_left;
    logic              w_rol;
    logic              w_fill;
    logic [WORD_W-1:0] w_stg [SH_W+1];
    // SUB and NEG reuse the adder: a + ~b + 1, with a forced to 0 for NEG.
    assign w_sub  = (alu_op == OP_SUB) || (alu_op == OP_NEG);
    assign w_a    = (alu_op == OP_NEG) ? '0 : x;
    assign w_b    = (alu_op == OP_NEG) ? x : y;
    assign w_sum  = w_a + (w_sub ? ~w_b : w_b) + {{(WORD_W-1){1'b0}}, w_sub};
    assign w_mul  = x * y;
    assign w_left = (alu_op == OP_SHL) || (alu_op == OP_ROL);
    assign w_rol  = (alu_op == OP_ROL);
    assign w_fill = (alu_op == OP_SRA) & x[WORD_W-1];
    assign w_stg[0] = x;
    for (genvar k = 0; k < SH_W; k++) begin : g_sh
        localparam int N = 1 << k;
        logic [WORD_W-1:0] w_l;
        logic [WORD_W-1:0] w_r;
        assign w_l = {w_stg[k][WORD_W-N-1:0], w_rol ? w_stg[k][WORD_W-1:WORD_W-N] : {N{1'b0}}};
        assign w_r = {{N{w_fill}}, w_stg[k][WORD_W-1:N]};
        assign w_stg[k+1] = y[k] ? (w_left ? w_l : w_r) : w_stg[k];
    end
    always_comb begin
        result = '0;
        case (alu_op)
            OP_ADD, OP_SUB, OP_NEG:         result = w_sum;
            OP_AND:                         result = x & y;
            OP_OR:                          result = x | y;
            OP_XOR:                         result = x ^ y;
            OP_NOT:                         result = ~x;
            OP_SHL, OP_SHR, OP_SRA, OP_ROL: result = w_stg[SH_W];
            OP_SLT:                         result = {{(WORD_W-1){1'b0}}, $signed(x) < $signed(y)};
            OP_SLTU:                        result = {{(WORD_W-1){1'b0}}, x < y};
            OP_MUL:                         result = w_mul;
            OP_PASSX:                       result = x;
            OP_PASSY:                       result = y;
            OP_ANY:                         result = {{(WORD_W-1){1'b0}}, |x};
            default:                        result = '0;
        endcase
    end
endmodule

// File: rtl/alu.sv
// alu: registered ALU; the combinational core followed by one output register.
module alu #(
    parameter int WORD_W = alu_pkg::WORD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        alu_op,
    input  logic [WORD_W-1:0] x,
    input  logic [WORD_W-1:0] y,
    output logic [WORD_W-1:0] z
);
    logic [WORD_W-1:0] w_result;
    logic [WORD_W-1:0] r_z;
    alu_core #(.WORD_W(WORD_W)) u_core (
        .alu_op (alu_op),
        .x      (x),
        .y      (y),
        .result (w_result)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_z <= '0;
        else        r_z <= w_result;
    end
    assign z = r_z;
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed-vector bench for the registered ALU.
module tb_alu;
    import alu_pkg::*;
    logic    clk = 1'b0;
    logic    rst_n = 1'b0;
    alu_op_t alu_op = OP_ADD;
    word_t   x = '0;
    word_t   y = '0;
    word_t   z;
    int      n_chk = 0;
    int      n_err = 0;

    alu u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .alu_op (alu_op),
        .x      (x),
        .y      (y),
        .z      (z)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input word_t got, input word_t exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // One vector per cycle: drive at negedge, sample just after the capturing edge.
    task automatic step(input string tag, input alu_op_t op, input word_t a, input word_t b, input word_t e);
        @(negedge clk);
        alu_op = op;
        x = a;
        y = b;
        @(posedge clk);
        #1;
        check(tag, z, e);
    endtask

    initial begin
        alu_op = OP_ADD;
        x = 16'h1234;
        y = 16'h0001;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", z, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_release", z, 16'h1235);

        step("add_wrap",   OP_ADD,   16'hFFFF, 16'h0001, 16'h0000);
        step("sub_wrap",   OP_SUB,   16'h0000, 16'h0001, 16'hFFFF);
        step("neg_8000",   OP_NEG,   16'h8000, 16'h1111, 16'h8000);
        step("neg_0001",   OP_NEG,   16'h0001, 16'h2222, 16'hFFFF);
        step("add",        OP_ADD,   16'h1234, 16'h4321, 16'h5555);
        step("sub",        OP_SUB,   16'h5000, 16'h1234, 16'h3DCC);
        step("and",        OP_AND,   16'hF0F0, 16'h3C3C, 16'h3030);
        step("or",         OP_OR,    16'hF0F0, 16'h3C3C, 16'hFCFC);
        step("xor",        OP_XOR,   16'hF0F0, 16'h3C3C, 16'hCCCC);
        step("not",        OP_NOT,   16'hF0F0, 16'h3C3C, 16'h0F0F);
        step("shl1",       OP_SHL,   16'h8001, 16'h0001, 16'h0002);
        step("shr4",       OP_SHR,   16'h8001, 16'h0004, 16'h0800);
        step("sra4",       OP_SRA,   16'h8001, 16'h0004, 16'hF800);
        step("rol1",       OP_ROL,   16'h8001, 16'h0001, 16'h0003);
        step("shl0",       OP_SHL,   16'h8001, 16'h0010, 16'h8001);
        step("shr0",       OP_SHR,   16'h8001, 16'h0010, 16'h8001);
        step("sra0",       OP_SRA,   16'h8001, 16'h0010, 16'h8001);
        step("rol0",       OP_ROL,   16'h8001, 16'h0010, 16'h8001);
        step("rol4",       OP_ROL,   16'h8001, 16'hFFF4, 16'h0018);
        step("shl15",      OP_SHL,   16'h0001, 16'h000F, 16'h8000);
        step("sra_pos",    OP_SRA,   16'h7FF0, 16'h0004, 16'h07FF);
        step("shr15",      OP_SHR,   16'h8000, 16'h000F, 16'h0001);
        step("slt_neg",    OP_SLT,   16'hFFFF, 16'h0001, 16'h0001);
        step("sltu_neg",   OP_SLTU,  16'hFFFF, 16'h0001, 16'h0000);
        step("slt_pos",    OP_SLT,   16'h0001, 16'hFFFF, 16'h0000);
        step("sltu_pos",   OP_SLTU,  16'h0001, 16'hFFFF, 16'h0001);
        step("slt_eq",     OP_SLT,   16'h1234, 16'h1234, 16'h0000);
        step("mul_ovf",    OP_MUL,   16'h0100, 16'h0100, 16'h0000);
        step("mul_neg",    OP_MUL,   16'h0003, 16'hFFFF, 16'hFFFD);
        step("mul",        OP_MUL,   16'h0012, 16'h0034, 16'h03A8);
        step("any0",       OP_ANY,   16'h0000, 16'hFFFF, 16'h0000);
        step("any1",       OP_ANY,   16'h0040, 16'h0000, 16'h0001);
        step("passx",      OP_PASSX, 16'hABCD, 16'h1234, 16'hABCD);
        step("passy",      OP_PASSY, 16'hABCD, 16'h1234, 16'h1234);
        step("rsv_10001",  5'b10001, 16'hABCD, 16'h1234, 16'h0000);
        step("rsv_11111",  5'b11111, 16'hFFFF, 16'hFFFF, 16'h0000);
        step("rsv_10100",  5'b10100, 16'h5555, 16'hAAAA, 16'h0000);
        step("after_rsv",  OP_ADD,   16'h1111, 16'h1111, 16'h2222);

        // Asynchronous reset mid-stream clears z without waiting for a clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clear", z, 16'h0000);
        @(posedge clk);
        #1;
        check("reset_mid_hold", z, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_reset", OP_XOR,   16'h00FF, 16'h0F0F, 16'h0FF0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/alu.md
# alu

Single-cycle, registered 16-bit arithmetic/logic unit for the processor datapath. Each clock it combines operands `x` and `y` under a 5-bit opcode and registers the 16-bit result on `z`. The execute stage instantiates it, and unit benches drive it directly with opcode/operand/expected-result vectors.

## Interface
- `WORD_W`, default 16: datapath word width. All arithmetic rules below assume 16.
- `clk`, input, 1 bit: rising-edge clock.
- `rst_n`, input, 1 bit: asynchronous, active-low reset.
- `alu_op`, input, 5 bits: operation select.
- `x`, input, 16 bits: first operand.
- `y`, input, 16 bits: second operand, or the shift/rotate amount.
- `z`, output, 16 bits: registered result.

## Operation
Opcode encoding is binary. All arithmetic is modulo 2^16, and no flags are produced.
- 00000 ADD: x + y; carry discarded.
- 00001 SUB: x − y, two's complement.
- 00010 AND: x & y.
- 00011 OR: x | y.
- 00100 XOR: x ^ y.
- 00101 NOT: ~x; y ignored.
- 00110 NEG: 0 − x; y ignored.
- 00111 SHL: x << y[3:0]; zero fill.
- 01000 SHR: x >> y[3:0]; logical, zero fill.
- 01001 SRA: x >>> y[3:0]; sign fill from x[15].
- 01010 ROL: x rotated left by y[3:0].
- 01011 SLT: 1 if signed x < signed y, else 0.
- 01100 SLTU: 1 if unsigned x < unsigned y, else 0.
- 01101 MUL: low 16 bits of x × y; the low half is sign-agnostic.
- 01110 PASSX: x.
- 01111 PASSY: y.
- 10000 ANY: 1 if x ≠ 0, else 0.
- 10001–11111 reserved: result 0x0000.
- Shift and rotate amounts use y[3:0] only; y[15:4] is ignored. A shift by 0 returns x unchanged.
- Every input is treated as defined. X/Z on inputs need not be handled specially.

## Timing
- The result is computed combinationally from the current `alu_op`, `x` and `y`, then captured into `z` on the next rising `clk`.
- Latency is 1 cycle. Throughput is 1 operation per cycle. There is no handshake, so a new operation is accepted every cycle.
- Reset: `rst_n` low clears `z` to 0x0000 immediately, independent of `clk`. It holds `z` at 0 while low.
- The first edge after `rst_n` rises captures the current inputs normally.
- If reset asserts mid-stream, any in-flight result is lost. Nothing else is stored.
- If inputs change between edges, only the values present at the capturing edge matter.

## Structure
- Shared package `alu_pkg` holds:
  - `WORD_W`;
  - a word typedef;
  - an `alu_op_t` 5-bit typedef;
  - named constants for all 17 opcodes.
- Sub-module `alu_core`: purely combinational `(alu_op, x, y) -> result`, with the reserved-opcode default.
- The `alu` top adds only the output register with asynchronous reset. This split lets the core be reused in a later single-cycle datapath without the register.
- Implement the shifter as a 4-stage barrel shifter shared by SHL, SHR, SRA and ROL. Implement SUB and NEG with the ADD adder (invert plus carry-in).

## Test plan
- Reset: hold `rst_n`=0 with x=0x1234, y=0x0001, op=ADD, clk toggling → `z`=0x0000. Release `rst_n`; next edge → `z`=0x1235.
- Add/sub wrap: ADD 0xFFFF+0x0001 → 0x0000. SUB 0x0000−0x0001 → 0xFFFF. NEG 0x8000 → 0x8000. NEG 0x0001 → 0xFFFF.
- Logic: x=0xF0F0, y=0x3C3C → AND 0x3030, OR 0xFCFC, XOR 0xCCCC, NOT 0x0F0F.
- Shifts, x=0x8001:
  - SHL by 1 → 0x0002.
  - SHR by 4 → 0x0800.
  - SRA by 4 → 0xF800.
  - ROL by 1 → 0x0003.
  - y=0x0010 (amount 0) → 0x8001 for all four.
- Compares and multiply:
  - SLT x=0xFFFF, y=0x0001 → 1; SLTU same operands → 0.
  - MUL 0x0100×0x0100 → 0x0000; MUL 0x0003×0xFFFF → 0xFFFD.
  - ANY 0 → 0; ANY 0x0040 → 1.
- Back-to-back and reserved opcodes: change op/operands every cycle across all 17 opcodes. Each `z` must equal the prior cycle's expected result. Ops 10001 and 11111 with nonzero operands → 0x0000.
